pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC and selects among sequential, redirect,
// trap entry and trap return, with a BOOT/RUN/HALTED sequencing FSM.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        mret_valid,
  input  logic        halt,
  input  logic        resume,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TRAP  = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, epc_nxt;
  logic [1:0]  cause_nxt;
  logic        redirect_misaligned;

  // Sequential increment; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] cur);
    seq_pc = cur + 32'd4;
  endfunction

  assign redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

  // req_valid depends only on state and stall, never on req_ready.
  assign req_valid = (state == RUN) && !stall;
  assign halted    = (state == HALTED);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    cause_nxt = cause;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_nxt    = TRAP_VECTOR;
          epc_nxt   = trap_pc;
          cause_nxt = CAUSE_TRAP;
        end else if (redirect_misaligned) begin
          pc_nxt    = TRAP_VECTOR;
          epc_nxt   = redirect_target;
          cause_nxt = CAUSE_ALIGN;
        end else if (mret_valid) begin
          pc_nxt    = epc;
          cause_nxt = CAUSE_NONE;
        end else if (redirect_valid) begin
          pc_nxt = redirect_target;
        end else if (!stall && req_ready) begin
          pc_nxt = seq_pc(pc);
        end
        if (halt) state_nxt = HALTED;
      end
      HALTED: begin
        // Only a trap or resume leaves HALTED; redirect and mret are dropped.
        if (trap_valid) begin
          pc_nxt    = TRAP_VECTOR;
          epc_nxt   = trap_pc;
          cause_nxt = CAUSE_TRAP;
          state_nxt = RUN;
        end else if (resume && !halt) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      epc   <= 32'h0;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
      cause <= cause_nxt;
    end
  end

endmodule
